// File: rtl/vga_ahb_pkg.sv
// Shared constants and types for the VGA character writer.
package vga_ahb_pkg;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [31:0] VGA_BASE_ADDR = 32'h5000_0000;

    typedef logic [7:0] char_t;
endpackage

// File: rtl/char_fifo.sv
// Synchronous character FIFO with occupancy count; push is refused while full.
module char_fifo
    import vga_ahb_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          push,
    input  char_t         din,
    input  logic          pop,
    output char_t         dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    char_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // a pop in the same cycle does not make room for a push into a full FIFO
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge HCLK) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ahb_vga_char_writer.sv
// AHB-Lite initiator that streams buffered console characters into the VGA text
// register as single NONSEQ word writes, halting on a lockstep mismatch.
module ahb_vga_char_writer
    import vga_ahb_pkg::*;
#(
    parameter  int          DEPTH     = 8,
    parameter  logic [31:0] BASE_ADDR = VGA_BASE_ADDR,
    localparam int          CW        = $clog2(DEPTH + 1)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          char_valid,
    input  logic [7:0]    char_data,
    output logic          char_ready,
    output logic          HSEL_VGA,
    output logic [31:0]   HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic          DLS_ERROR,
    input  logic          clear_halt,
    output logic          halted,
    output logic [CW-1:0] fifo_count,
    output logic          busy
);
    char_t head, wdata_q;
    logic  full, empty, push, pop, issue;
    logic  halted_q, hold_q, data_phase_q, rdy_en_q;

    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (push),
        .din     (char_data),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign char_ready = rdy_en_q && !full && !halted_q;
    assign push       = char_valid && char_ready;
    // a NONSEQ stalled by HREADY=0 is an AHB commitment and outlives a halt
    assign issue      = !empty && (!halted_q || hold_q);
    assign pop        = issue && HREADY;

    assign HTRANS   = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSEL_VGA = HTRANS[1];
    assign HWRITE   = HTRANS[1];
    assign HADDR    = BASE_ADDR;
    // wdata_q only changes on acceptance, so HWDATA holds outside data phases
    assign HWDATA   = {24'h0, wdata_q};
    assign halted   = halted_q;
    assign busy     = !empty || data_phase_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdy_en_q     <= 1'b0;
            halted_q     <= 1'b0;
            hold_q       <= 1'b0;
            data_phase_q <= 1'b0;
            wdata_q      <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            hold_q   <= issue && !HREADY;
            if (DLS_ERROR)
                halted_q <= 1'b1;
            else if (clear_halt)
                halted_q <= 1'b0;
            if (pop) begin
                wdata_q      <= head;
                data_phase_q <= 1'b1;
            end else if (HREADY) begin
                data_phase_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_vga_char_writer.sv
// Scoreboard bench for ahb_vga_char_writer: pushed characters are queued and
// matched against HWDATA as each data phase completes.
module tb_ahb_vga_char_writer;
    localparam logic [31:0] BASE = 32'h5000_0000;

    logic        HCLK = 0, HRESETn = 0, char_valid = 0, HREADY = 1;
    logic        DLS_ERROR = 0, clear_halt = 0;
    logic [7:0]  char_data = 0;
    logic        char_ready, HSEL_VGA, HWRITE, halted, busy;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [3:0]  fifo_count;

    int          checks = 0, errors = 0, n_acc = 0, peak = 0;
    logic [7:0]  exp_q[$];
    logic        dp = 0;

    ahb_vga_char_writer dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .HSEL_VGA(HSEL_VGA), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .DLS_ERROR(DLS_ERROR),
        .clear_halt(clear_halt), .halted(halted), .fifo_count(fifo_count), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Bus monitor: samples at negedge, i.e. the values the next posedge will see.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dp = 0;
                continue;
            end
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (dp && HREADY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wdata_unexpected: got %h, no write expected", HWDATA);
                end else begin
                    e = exp_q.pop_front();
                    if (HWDATA !== {24'h0, e}) begin
                        errors++;
                        $display("FAIL wdata_order: got %h exp %h", HWDATA, {24'h0, e});
                    end
                end
                dp = 0;
            end
            if (HTRANS === 2'b10) begin
                checks++;
                if (HADDR !== BASE || HWRITE !== 1'b1 || HSEL_VGA !== 1'b1) begin
                    errors++;
                    $display("FAIL addr_ctrl: got addr %h wr %b sel %b exp %h 1 1",
                             HADDR, HWRITE, HSEL_VGA, BASE);
                end
                if (HREADY) begin
                    dp = 1;
                    n_acc++;
                end
            end else if (HTRANS !== 2'b00) begin
                checks++;
                errors++;
                $display("FAIL htrans_legal: got %b exp 00 or 10", HTRANS);
            end
        end
    endtask

    task automatic push_char(input logic [7:0] c);
        int n = 0;
        char_valid = 1;
        char_data  = c;
        while (!char_ready && n < 200) begin
            tick();
            n++;
        end
        if (!char_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: char %h ready %b exp 1", c, char_ready);
        end else begin
            exp_q.push_back(c);
            tick();
        end
        char_valid = 0;
    endtask

    task automatic wait_drain(output int cyc);
        cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL drain: busy %b pending %0d count %0d exp 0 0 0", busy, exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (HTRANS !== 2'b00 || HSEL_VGA !== 0 || HWRITE !== 0 || HADDR !== BASE || HWDATA !== 0) begin
            errors++;
            $display("FAIL reset_bus: got %b %b %b %h %h exp 00 0 0 %h 0", HTRANS, HSEL_VGA, HWRITE, HADDR, HWDATA, BASE);
        end
        checks++;
        if (halted !== 0 || fifo_count !== 0 || busy !== 0 || char_ready !== 0) begin
            errors++;
            $display("FAIL reset_status: got h%b c%0d b%b r%b exp 0 0 0 0", halted, fifo_count, busy, char_ready);
        end
        tick();
        HRESETn = 1;
        tick();
        checks++;
        if (char_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b exp 1", char_ready);
        end
    endtask

    task automatic test_single();
        int cyc;
        HREADY = 1;
        push_char(8'h41);
        checks++;
        if (HTRANS !== 2'b10 || HSEL_VGA !== 1 || HWRITE !== 1 || HADDR !== BASE) begin
            errors++;
            $display("FAIL single_addr: got %b %b %b %h exp 10 1 1 %h", HTRANS, HSEL_VGA, HWRITE, HADDR, BASE);
        end
        tick();
        checks++;
        if (HWDATA !== 32'h41 || HTRANS !== 2'b00 || busy !== 1) begin
            errors++;
            $display("FAIL single_data: got %h %b busy %b exp 00000041 00 1", HWDATA, HTRANS, busy);
        end
        tick();
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL single_idle: busy %b exp 0", busy);
        end
        wait_drain(cyc);
    endtask

    task automatic test_back_to_back();
        int cyc, a0;
        HREADY = 1;
        peak = 0;
        a0 = n_acc;
        for (int i = 0; i < 8; i++) push_char(8'h30 + 8'(i));
        wait_drain(cyc);
        checks++;
        if (peak != 1 || n_acc - a0 != 8 || cyc > 2) begin
            errors++;
            $display("FAIL b2b_rate: peak %0d writes %0d drain %0d exp 1 8 <=2", peak, n_acc - a0, cyc);
        end
    endtask

    task automatic test_stall_fill();
        int cyc, a0;
        HREADY = 0;
        a0 = n_acc;
        for (int i = 0; i < 8; i++) push_char(8'hA0 + 8'(i));
        checks++;
        if (fifo_count !== 4'd8 || char_ready !== 0 || HTRANS !== 2'b10) begin
            errors++;
            $display("FAIL stall_full: count %0d ready %b trans %b exp 8 0 10", fifo_count, char_ready, HTRANS);
        end
        char_valid = 1;
        char_data  = 8'hEE;
        repeat (3) tick();
        char_valid = 0;
        checks++;
        if (fifo_count !== 4'd8 || HTRANS !== 2'b10 || HADDR !== BASE || n_acc != a0) begin
            errors++;
            $display("FAIL stall_hold: count %0d trans %b addr %h writes %0d exp 8 10 %h 0",
                     fifo_count, HTRANS, HADDR, n_acc - a0, BASE);
        end
        HREADY = 1;
        wait_drain(cyc);
        checks++;
        if (n_acc - a0 != 8) begin
            errors++;
            $display("FAIL stall_drain: writes %0d exp 8", n_acc - a0);
        end
    endtask

    task automatic test_wait_data();
        int cyc;
        HREADY = 1;
        push_char(8'h55);
        char_valid = 1;
        char_data  = 8'h56;
        exp_q.push_back(8'h56);
        tick();
        char_valid = 0;
        HREADY = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (HWDATA !== 32'h55 || HTRANS !== 2'b10 || fifo_count !== 4'd1) begin
                errors++;
                $display("FAIL wait_hold: cyc %0d wdata %h trans %b count %0d exp 55 10 1", i, HWDATA, HTRANS, fifo_count);
            end
            tick();
        end
        HREADY = 1;
        wait_drain(cyc);
    endtask

    task automatic test_halt();
        int a0;
        HREADY = 0;
        for (int i = 0; i < 6; i++) push_char(8'h60 + 8'(i));
        a0 = n_acc;
        HREADY = 1;
        tick();
        tick();
        DLS_ERROR = 1;
        tick();
        DLS_ERROR = 0;
        checks++;
        if (halted !== 1 || char_ready !== 0 || HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL halt_set: halted %b ready %b trans %b exp 1 0 00", halted, char_ready, HTRANS);
        end
        char_valid = 1;
        char_data  = 8'hEF;
        repeat (4) tick();
        char_valid = 0;
        checks++;
        if (n_acc - a0 != 3 || fifo_count !== 4'd3 || halted !== 1 || busy !== 1) begin
            errors++;
            $display("FAIL halt_retain: writes %0d count %0d halted %b busy %b exp 3 3 1 1",
                     n_acc - a0, fifo_count, halted, busy);
        end
    endtask

    task automatic test_release();
        int cyc, a0;
        a0 = n_acc;
        DLS_ERROR  = 1;
        clear_halt = 1;
        tick();
        DLS_ERROR  = 0;
        clear_halt = 0;
        tick();
        checks++;
        if (halted !== 1 || n_acc != a0) begin
            errors++;
            $display("FAIL clear_blocked: halted %b writes %0d exp 1 0", halted, n_acc - a0);
        end
        clear_halt = 1;
        tick();
        clear_halt = 0;
        checks++;
        if (halted !== 0 || char_ready !== 1) begin
            errors++;
            $display("FAIL release: halted %b ready %b exp 0 1", halted, char_ready);
        end
        wait_drain(cyc);
        checks++;
        if (n_acc - a0 != 3) begin
            errors++;
            $display("FAIL release_writes: got %0d exp 3", n_acc - a0);
        end
    endtask

    task automatic test_reset_mid();
        HREADY = 1;
        push_char(8'h77);
        push_char(8'h78);
        HREADY    = 0;
        DLS_ERROR = 1;
        tick();
        DLS_ERROR = 0;
        #2;
        HRESETn = 0;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || fifo_count !== 0 || halted !== 0 || HWDATA !== 0 || busy !== 0 || HSEL_VGA !== 0) begin
            errors++;
            $display("FAIL reset_mid: trans %b count %0d halted %b wdata %h busy %b sel %b exp 00 0 0 0 0 0",
                     HTRANS, fifo_count, halted, HWDATA, busy, HSEL_VGA);
        end
        exp_q.delete();
        HREADY = 1;
        tick();
        HRESETn = 1;
        tick();
        tick();
        checks++;
        if (char_ready !== 1 || HTRANS !== 2'b00 || busy !== 0) begin
            errors++;
            $display("FAIL reset_recover: ready %b trans %b busy %b exp 1 00 0", char_ready, HTRANS, busy);
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_fill();
        test_wait_data();
        test_halt();
        test_release();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_vga_char_writer.md
Name: ahb_vga_char_writer

Overview:
AHB-Lite initiator that drives the VGA peripheral's slave port (HSEL_VGA/HADDR/HTRANS/HWRITE/HWDATA/HREADY). Accepts a valid/ready byte stream of console characters, buffers it in a small FIFO, and issues single NONSEQ word writes to the VGA text register. Honours slave wait states. Halts issuing on the lockstep comparator's DLS_ERROR so that no further writes reach a diverged primary/redundant pair.

Parameters:
DEPTH, 8, FIFO entries; power of two, >=2
BASE_ADDR, 32'h5000_0000, VGA text register address driven on HADDR

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
char_valid  in  1  character offered
char_data  in  8  character code
char_ready  out  1  FIFO can accept a character
HSEL_VGA  out  1  slave select; equal to HTRANS[1]
HADDR  out  32  transfer address
HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only
HWRITE  out  1  equal to HTRANS[1]
HWDATA  out  32  write data, data phase
HREADY  in  1  bus ready / previous transfer complete
DLS_ERROR  in  1  lockstep mismatch from the comparator
clear_halt  in  1  one-cycle pulse that releases the halt
halted  out  1  sticky halt flag
fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy
busy  out  1  FIFO non-empty or data phase outstanding

Behaviour:
- Interface decision: one clock, HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: HTRANS=IDLE, HSEL_VGA=0, HWRITE=0, HADDR=BASE_ADDR (constant), HWDATA=0, halted=0, fifo_count=0, busy=0. char_ready is 0 while in reset and 1 after reset release.
- char_ready = !full && !halted. Push occurs on an edge with char_valid && char_ready.
- When full, a push is refused even if a pop happens in the same cycle.
- Address phase:
  - HTRANS=NONSEQ whenever the FIFO is non-empty and issuing is enabled.
  - The address phase is accepted on an edge with HREADY=1. At that edge the FIFO head is popped into wdata_q and data_phase_q is set to 1.
  - While HREADY=0, a presented NONSEQ is held unchanged. It is never withdrawn and the FIFO head is not popped.
- Data phase:
  - HWDATA = {24'h0, wdata_q} while data_phase_q=1; otherwise HWDATA holds its last value.
  - The data phase completes on an edge with HREADY=1. data_phase_q clears unless a new address phase is accepted at the same edge (pipelined).
- Latency and throughput:
  - A character pushed at edge N is presented as NONSEQ in cycle N+1 and accepted at edge N+1 if HREADY=1.
  - Its HWDATA is valid in cycle N+2.
  - With HREADY held high, throughput is one write per cycle.
- Ordering: characters are written in push order, with no loss or duplication.
- Halt:
  - DLS_ERROR sampled high sets halted at that edge.
  - From the next cycle, no new NONSEQ is started. A NONSEQ already presented while HREADY=0 is held until accepted; the AHB commitment takes precedence.
  - An outstanding data phase completes normally. FIFO contents are retained. char_ready=0.
- Release:
  - clear_halt clears halted only if DLS_ERROR=0 in the same cycle.
  - If DLS_ERROR and clear_halt are both high in one cycle, halted remains set.
  - After release, issuing resumes from the retained FIFO head.
- Simultaneous push and pop: fifo_count is unchanged.
- Count and pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count never exceeds DEPTH or underflows.
- Reset mid-transfer: all state clears immediately. An outstanding bus transfer is abandoned and HTRANS=IDLE.

Decomposition:
- Package vga_ahb_pkg holds:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - VGA_BASE_ADDR=32'h5000_0000
  - localparam typedef char_t (logic [7:0])
- One sub-module, char_fifo: synchronous FIFO with full/empty/count and DEPTH parameter, using the same HCLK/HRESETn.
- The top level holds the address/data-phase control, the halt logic and the bus outputs.

Test Plan:
- Single char 8'h41, HREADY=1 -> one NONSEQ at BASE_ADDR with HWRITE=1 and HSEL_VGA=1 one cycle after push; HWDATA=32'h0000_0041 the next cycle; then IDLE; busy drops.
- Push 8 chars 0x30..0x37 back-to-back, HREADY=1 -> 8 consecutive NONSEQ cycles; HWDATA sequence 0x30..0x37; fifo_count peaks at 1.
- Push 8 chars while HREADY=0 -> fifo_count 8 after push; NONSEQ held with HADDR constant; char_ready=0. Raise HREADY -> all 8 drain in order.
- HREADY low for 3 cycles during data phase of 0x55 -> HWDATA holds 32'h55; next address phase remains held; no pop until HREADY=1.
- DLS_ERROR pulse after the 3rd of 6 chars -> halted=1; at most one further accepted write; remaining chars retained in fifo_count; char_ready=0.
- Then clear_halt with DLS_ERROR=0 -> the remaining chars are written in order.
- Assert HRESETn low mid data phase -> HTRANS=IDLE, fifo_count=0, halted=0, HWDATA=0, all asynchronously.
